// File: rtl/led_pkg.sv
// Shared types and helpers for the LED PWM controller: channel modes,
// press-sequence stepping and breathe direction constants.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic mode_e mode_next(input mode_e m);
    case (m)
      MODE_OFF:   mode_next = MODE_ON;
      MODE_ON:    mode_next = MODE_BLINK;
      MODE_BLINK: mode_next = MODE_BREATHE;
      default:    mode_next = MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/led_chan.sv
// One LED channel: mode register, brightness level generator (blink/breathe),
// frame-aligned duty shadow and registered PWM comparator.
module led_chan
  import led_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int BLINK_STEPS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_end,
  input  logic                step_ev,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                btn_press,
  input  logic                mode_wr,
  input  logic [1:0]          mode_wdata,
  output logic                pwm,
  output logic [1:0]          mode
);

  localparam int BCW = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;
  localparam logic [PWM_BITS-1:0] LVL_MAX    = '1;
  localparam logic [BCW-1:0]      BLINK_LAST = BCW'(BLINK_STEPS - 1);

  mode_e               mode_q, mode_d, mode_new;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                dir_q, dir_d;
  logic [BCW-1:0]      blink_cnt_q, blink_cnt_d;
  logic                pwm_q, pwm_d;
  logic                mode_chg;

  // Triangle ramp with saturation at both ends; returns {dir, level}.
  function automatic logic [PWM_BITS:0] breathe_step(input logic dir,
                                                     input logic [PWM_BITS-1:0] lvl);
    logic [PWM_BITS-1:0] nxt;
    logic                nd;
    nd = dir;
    if (dir == DIR_UP) begin
      nxt = (lvl == LVL_MAX) ? lvl : lvl + PWM_BITS'(1);
      if (nxt == LVL_MAX) nd = DIR_DOWN;
    end else begin
      nxt = (lvl == '0) ? lvl : lvl - PWM_BITS'(1);
      if (nxt == '0) nd = DIR_UP;
    end
    return {nd, nxt};
  endfunction

  always_comb begin
    mode_chg    = mode_wr | btn_press;
    mode_new    = mode_wr ? mode_e'(mode_wdata) : mode_next(mode_q);
    mode_d      = mode_q;
    level_d     = level_q;
    dir_d       = dir_q;
    blink_cnt_d = blink_cnt_q;
    // A landing mode change takes priority over any ramp step in the same cycle.
    if (mode_chg) begin
      mode_d      = mode_new;
      level_d     = (mode_new == MODE_ON || mode_new == MODE_BLINK) ? LVL_MAX : '0;
      dir_d       = DIR_UP;
      blink_cnt_d = '0;
    end else if (step_ev) begin
      case (mode_q)
        MODE_BLINK: begin
          if (blink_cnt_q == BLINK_LAST) begin
            level_d     = (level_q == '0) ? LVL_MAX : '0;
            blink_cnt_d = '0;
          end else begin
            blink_cnt_d = blink_cnt_q + BCW'(1);
          end
        end
        MODE_BREATHE: {dir_d, level_d} = breathe_step(dir_q, level_q);
        default: ;
      endcase
    end
    duty_d = frame_end ? level_q : duty_q;
    pwm_d  = (pwm_cnt < duty_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= MODE_OFF;
      level_q     <= '0;
      duty_q      <= '0;
      dir_q       <= DIR_UP;
      blink_cnt_q <= '0;
      pwm_q       <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      level_q     <= level_d;
      duty_q      <= duty_d;
      dir_q       <= dir_d;
      blink_cnt_q <= blink_cnt_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pwm  = pwm_q;
  assign mode = mode_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// N-channel LED brightness controller: shared PWM/frame/step timers feeding
// one led_chan per channel; outputs drive the RGB driver PWM inputs.
module led_pwm_ctrl
  import led_pkg::*;
#(
  parameter int NCH         = 3,
  parameter int PWM_BITS    = 8,
  parameter int STEP_FRAMES = 1024,
  parameter int BLINK_STEPS = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   btn_press,
  input  logic [NCH-1:0]   mode_wr,
  input  logic [2*NCH-1:0] mode_wdata,
  output logic [NCH-1:0]   pwm,
  output logic [2*NCH-1:0] mode,
  output logic             step
);

  localparam int FCW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(STEP_FRAMES - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [FCW-1:0]      frame_cnt_q, frame_cnt_d;
  logic                step_q, step_d;
  logic                frame_end, step_ev;

  always_comb begin
    frame_end   = (pwm_cnt_q == '1);
    step_ev     = frame_end && (frame_cnt_q == FRAME_LAST);
    pwm_cnt_d   = pwm_cnt_q + PWM_BITS'(1);
    frame_cnt_d = frame_cnt_q;
    if (frame_end) frame_cnt_d = step_ev ? '0 : frame_cnt_q + FCW'(1);
    step_d      = step_ev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_q   <= '0;
      frame_cnt_q <= '0;
      step_q      <= 1'b0;
    end else begin
      pwm_cnt_q   <= pwm_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      step_q      <= step_d;
    end
  end

  assign step = step_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    led_chan #(
      .PWM_BITS   (PWM_BITS),
      .BLINK_STEPS(BLINK_STEPS)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .frame_end (frame_end),
      .step_ev   (step_ev),
      .pwm_cnt   (pwm_cnt_q),
      .btn_press (btn_press[i]),
      .mode_wr   (mode_wr[i]),
      .mode_wdata(mode_wdata[2*i +: 2]),
      .pwm       (pwm[i]),
      .mode      (mode[2*i +: 2])
    );
  end

endmodule
